// File: rtl/proc_pkg.sv
`default_nettype none
// ============================================================================
// Module : proc_pkg
// Brief  : Opcode and source encodings and instruction field layout shared by
//          the instruction issue unit and its ALU.
// Rev    : 1.0
// ============================================================================
package proc_pkg;

    // Default instruction layout: [7:6] opcode, [5:4] src0, [3:2] src1, [1] dst0, [0] dst1
    localparam int c_OPCODE_W   = 2;
    localparam int c_SRC_W      = 2;
    localparam int c_DST_W      = 1;
    localparam int c_INST_W     = 8;
    localparam int c_DATA_W     = 8;
    localparam int c_DST1_LSB   = 0;
    localparam int c_DST0_LSB   = 1;
    localparam int c_SRC1_LSB   = 2;
    localparam int c_SRC0_LSB   = 4;
    localparam int c_OPCODE_LSB = 6;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_XOR = 2'b11
    } opcode_e;

    typedef enum logic [1:0] {
        SRC_INT  = 2'b00,
        SRC_NIN  = 2'b01,
        SRC_ACC  = 2'b10,
        SRC_ZERO = 2'b11
    } src_e;

endpackage
`default_nettype wire

// File: rtl/inst_issue_unit_alu.sv
`default_nettype none
// ============================================================================
// Module : alu
// Brief  : Combinational ALU; result wraps modulo 2^DATA_WIDTH, no flags.
// Rev    : 1.0
// ============================================================================
module alu
    import proc_pkg::*;
#(
    parameter int DATA_WIDTH   = c_DATA_W,
    parameter int OPCODE_WIDTH = c_OPCODE_W
) (
    input  logic [OPCODE_WIDTH-1:0] opcode_i,
    input  logic [DATA_WIDTH-1:0]   a_i,
    input  logic [DATA_WIDTH-1:0]   b_i,
    output logic [DATA_WIDTH-1:0]   result_o
);

    always_comb begin
        result_o = '0;
        case (opcode_i)
            OPCODE_WIDTH'(OP_ADD): result_o = a_i + b_i;
            OPCODE_WIDTH'(OP_SUB): result_o = a_i - b_i;
            OPCODE_WIDTH'(OP_AND): result_o = a_i & b_i;
            OPCODE_WIDTH'(OP_XOR): result_o = a_i ^ b_i;
            default:               result_o = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/inst_issue_unit.sv
`default_nettype none
// ============================================================================
// Module : inst_issue_unit
// Brief  : Issues instructions from a control FIFO onto FIFO/ACC operands and
//          retires results through a one-entry write-back stage to NOUT/BUS.
// Rev    : 1.0
// ============================================================================
module inst_issue_unit
    import proc_pkg::*;
#(
    parameter int DATA_WIDTH     = c_DATA_W,
    parameter int INST_WIDTH     = c_INST_W,
    parameter int OPCODE_WIDTH   = c_OPCODE_W,
    parameter int SRC0_IDX_WIDTH = c_SRC_W,
    parameter int SRC1_IDX_WIDTH = c_SRC_W,
    parameter int DST0_IDX_WIDTH = c_DST_W,
    parameter int DST1_IDX_WIDTH = c_DST_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ctrl_fifo_empty,
    input  logic [INST_WIDTH-1:0] ctrl_fifo_data_out,
    output logic                  ctrl_fifo_deq,
    input  logic                  int_fifo_empty,
    input  logic [DATA_WIDTH-1:0] int_fifo_data_out,
    output logic                  int_fifo_deq,
    input  logic                  nin_fifo_empty,
    input  logic [DATA_WIDTH-1:0] nin_fifo_data_out,
    output logic                  nin_fifo_deq,
    input  logic                  nout_fifo_full,
    output logic                  nout_fifo_enq,
    output logic [DATA_WIDTH-1:0] nout_fifo_data_in,
    input  logic                  bus_fifo_full,
    output logic                  bus_fifo_enq,
    output logic [DATA_WIDTH-1:0] bus_fifo_data_in,
    output logic [DATA_WIDTH-1:0] acc_out,
    output logic [15:0]           inst_count,
    output logic                  idle
);

    localparam int c_DST1_OFF = 0;
    localparam int c_DST0_OFF = c_DST1_OFF + DST1_IDX_WIDTH;
    localparam int c_SRC1_OFF = c_DST0_OFF + DST0_IDX_WIDTH;
    localparam int c_SRC0_OFF = c_SRC1_OFF + SRC1_IDX_WIDTH;
    localparam int c_OP_OFF   = c_SRC0_OFF + SRC0_IDX_WIDTH;

    logic [DATA_WIDTH-1:0]   acc_q,       acc_d;
    logic                    wb_valid_q,  wb_valid_d;
    logic [DATA_WIDTH-1:0]   wb_data_q,   wb_data_d;
    logic                    wb_dst0_q,   wb_dst0_d;
    logic                    wb_dst1_q,   wb_dst1_d;
    logic [15:0]             cnt_q,       cnt_d;

    logic [OPCODE_WIDTH-1:0] w_opcode;
    logic [1:0]              w_src0;
    logic [1:0]              w_src1;
    logic                    w_dst0;
    logic                    w_dst1;
    logic                    w_need_int;
    logic                    w_need_nin;
    logic                    w_fire;
    logic                    w_issue;
    logic [DATA_WIDTH-1:0]   w_opa;
    logic [DATA_WIDTH-1:0]   w_opb;
    logic [DATA_WIDTH-1:0]   w_result;

    function automatic logic [DATA_WIDTH-1:0] sel_operand(
        input logic [1:0]            code,
        input logic [DATA_WIDTH-1:0] int_head,
        input logic [DATA_WIDTH-1:0] nin_head,
        input logic [DATA_WIDTH-1:0] acc
    );
        logic [DATA_WIDTH-1:0] v;
        case (code)
            SRC_INT: v = int_head;
            SRC_NIN: v = nin_head;
            SRC_ACC: v = acc;
            default: v = '0;
        endcase
        return v;
    endfunction

    assign w_opcode = ctrl_fifo_data_out[c_OP_OFF +: OPCODE_WIDTH];
    assign w_src0   = 2'(ctrl_fifo_data_out[c_SRC0_OFF +: SRC0_IDX_WIDTH]);
    assign w_src1   = 2'(ctrl_fifo_data_out[c_SRC1_OFF +: SRC1_IDX_WIDTH]);
    assign w_dst0   = |ctrl_fifo_data_out[c_DST0_OFF +: DST0_IDX_WIDTH];
    assign w_dst1   = |ctrl_fifo_data_out[c_DST1_OFF +: DST1_IDX_WIDTH];

    // A source FIFO named by both operands is still popped only once
    assign w_need_int = (w_src0 == SRC_INT) || (w_src1 == SRC_INT);
    assign w_need_nin = (w_src0 == SRC_NIN) || (w_src1 == SRC_NIN);

    assign w_fire  = wb_valid_q && (!wb_dst0_q || !nout_fifo_full)
                                && (!wb_dst1_q || !bus_fifo_full);
    assign w_issue = !reset && !ctrl_fifo_empty
                  && (!w_need_int || !int_fifo_empty)
                  && (!w_need_nin || !nin_fifo_empty)
                  && (!wb_valid_q || w_fire);

    assign w_opa = sel_operand(w_src0, int_fifo_data_out, nin_fifo_data_out, acc_q);
    assign w_opb = sel_operand(w_src1, int_fifo_data_out, nin_fifo_data_out, acc_q);

    alu #(
        .DATA_WIDTH   (DATA_WIDTH),
        .OPCODE_WIDTH (OPCODE_WIDTH)
    ) u_alu (
        .opcode_i (w_opcode),
        .a_i      (w_opa),
        .b_i      (w_opb),
        .result_o (w_result)
    );

    always_comb begin
        acc_d      = acc_q;
        wb_valid_d = wb_valid_q;
        wb_data_d  = wb_data_q;
        wb_dst0_d  = wb_dst0_q;
        wb_dst1_d  = wb_dst1_q;
        cnt_d      = cnt_q;
        if (w_issue) begin
            acc_d      = w_result;
            wb_valid_d = 1'b1;
            wb_data_d  = w_result;
            wb_dst0_d  = w_dst0;
            wb_dst1_d  = w_dst1;
            cnt_d      = cnt_q + 16'd1;
        end else if (w_fire) begin
            wb_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_dst0_q  <= 1'b0;
            wb_dst1_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            acc_q      <= acc_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_dst0_q  <= wb_dst0_d;
            wb_dst1_q  <= wb_dst1_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ctrl_fifo_deq     = w_issue;
    assign int_fifo_deq      = w_issue && w_need_int;
    assign nin_fifo_deq      = w_issue && w_need_nin;
    assign nout_fifo_enq     = w_fire && wb_dst0_q;
    assign bus_fifo_enq      = w_fire && wb_dst1_q;
    assign nout_fifo_data_in = wb_data_q;
    assign bus_fifo_data_in  = wb_data_q;
    assign acc_out           = acc_q;
    assign inst_count        = cnt_q;
    assign idle              = ctrl_fifo_empty && !wb_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_issue_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_inst_issue_unit
// Brief  : Queue-backed FIFO environment with a behavioural model of the
//          issue unit; directed scenarios followed by random traffic.
// Rev    : 1.0
// ============================================================================
module tb_inst_issue_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       ctrl_fifo_empty, int_fifo_empty, nin_fifo_empty;
    logic [7:0] ctrl_fifo_data_out, int_fifo_data_out, nin_fifo_data_out;
    logic       ctrl_fifo_deq, int_fifo_deq, nin_fifo_deq;
    logic       nout_fifo_full, bus_fifo_full;
    logic       nout_fifo_enq, bus_fifo_enq;
    logic [7:0] nout_fifo_data_in, bus_fifo_data_in, acc_out;
    logic [15:0] inst_count;
    logic       idle;

    inst_issue_unit dut (
        .clk                (clk),
        .reset              (reset),
        .ctrl_fifo_empty    (ctrl_fifo_empty),
        .ctrl_fifo_data_out (ctrl_fifo_data_out),
        .ctrl_fifo_deq      (ctrl_fifo_deq),
        .int_fifo_empty     (int_fifo_empty),
        .int_fifo_data_out  (int_fifo_data_out),
        .int_fifo_deq       (int_fifo_deq),
        .nin_fifo_empty     (nin_fifo_empty),
        .nin_fifo_data_out  (nin_fifo_data_out),
        .nin_fifo_deq       (nin_fifo_deq),
        .nout_fifo_full     (nout_fifo_full),
        .nout_fifo_enq      (nout_fifo_enq),
        .nout_fifo_data_in  (nout_fifo_data_in),
        .bus_fifo_full      (bus_fifo_full),
        .bus_fifo_enq       (bus_fifo_enq),
        .bus_fifo_data_in   (bus_fifo_data_in),
        .acc_out            (acc_out),
        .inst_count         (inst_count),
        .idle               (idle)
    );

    always #5 clk = ~clk;

    logic [7:0] ctrl_q[$];
    logic [7:0] int_q[$];
    logic [7:0] nin_q[$];

    // Model state: accumulator, count and the single pending result
    logic [7:0]  m_acc;
    logic [15:0] m_cnt;
    logic        m_wbv, m_d0, m_d1;
    logic [7:0]  m_wbd;
    logic        m_issue, m_fire, m_ni, m_nn;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive();
        ctrl_fifo_empty    = (ctrl_q.size() == 0);
        ctrl_fifo_data_out = ctrl_fifo_empty ? 8'($urandom) : ctrl_q[0];
        int_fifo_empty     = (int_q.size() == 0);
        int_fifo_data_out  = int_fifo_empty ? 8'($urandom) : int_q[0];
        nin_fifo_empty     = (nin_q.size() == 0);
        nin_fifo_data_out  = nin_fifo_empty ? 8'($urandom) : nin_q[0];
    endtask

    task automatic model_reset();
        m_acc = '0; m_cnt = '0; m_wbv = 1'b0; m_d0 = 1'b0; m_d1 = 1'b0; m_wbd = '0;
        m_issue = 1'b0; m_fire = 1'b0;
    endtask

    function automatic logic [7:0] operand(input logic [1:0] code);
        case (code)
            2'b00:   return int_q[0];
            2'b01:   return nin_q[0];
            2'b10:   return m_acc;
            default: return 8'd0;
        endcase
    endfunction

    task automatic model_check();
        logic [7:0] inst;
        logic       ni, nn, e0, e1;
        inst    = (ctrl_q.size() != 0) ? ctrl_q[0] : 8'hFF;
        ni      = (inst[5:4] == 2'b00) || (inst[3:2] == 2'b00);
        nn      = (inst[5:4] == 2'b01) || (inst[3:2] == 2'b01);
        m_fire  = !reset && m_wbv && !(m_d0 && nout_fifo_full) && !(m_d1 && bus_fifo_full);
        m_issue = !reset && (ctrl_q.size() != 0) && !(ni && int_q.size() == 0)
                  && !(nn && nin_q.size() == 0) && (!m_wbv || m_fire);
        m_ni    = m_issue && ni;
        m_nn    = m_issue && nn;
        e0      = m_fire && m_d0;
        e1      = m_fire && m_d1;
        chk("ctrl_deq", ctrl_fifo_deq, m_issue);
        chk("int_deq",  int_fifo_deq,  m_ni);
        chk("nin_deq",  nin_fifo_deq,  m_nn);
        chk("nout_enq", nout_fifo_enq, e0);
        chk("bus_enq",  bus_fifo_enq,  e1);
        if (e0) chk("nout_data", nout_fifo_data_in, m_wbd);
        if (e1) chk("bus_data",  bus_fifo_data_in,  m_wbd);
        chk("acc_out",    acc_out,    m_acc);
        chk("inst_count", inst_count, m_cnt);
        chk("idle",       idle,       (ctrl_q.size() == 0) && !m_wbv);
    endtask

    task automatic model_update();
        logic [7:0] inst, a, b, r;
        if (reset) begin
            model_reset();
        end else if (m_issue) begin
            inst = ctrl_q.pop_front();
            a = operand(inst[5:4]);
            b = operand(inst[3:2]);
            case (inst[7:6])
                2'b00:   r = a + b;
                2'b01:   r = a - b;
                2'b10:   r = a & b;
                default: r = a ^ b;
            endcase
            if (m_ni) void'(int_q.pop_front());
            if (m_nn) void'(nin_q.pop_front());
            m_acc = r; m_cnt = m_cnt + 16'd1;
            m_wbv = 1'b1; m_wbd = r; m_d0 = inst[1]; m_d1 = inst[0];
        end else if (m_fire) begin
            m_wbv = 1'b0;
        end
    endtask

    task automatic at_neg();
        @(negedge clk);
        model_check();
    endtask

    task automatic post();
        @(posedge clk);
        #1;
        model_update();
        drive();
    endtask

    initial begin
        reset = 1'b1; nout_fifo_full = 1'b0; bus_fifo_full = 1'b0;
        model_reset(); drive();
        at_neg();
        chk("rst_idle", idle, 1); chk("rst_acc", acc_out, 0); chk("rst_cnt", inst_count, 0);
        @(posedge clk); #1; reset = 1'b0; model_reset(); drive();

        // ADD int+nin -> NOUT
        ctrl_q.push_back(8'b00_00_01_1_0); int_q.push_back(8'd5); nin_q.push_back(8'd7); drive();
        at_neg();
        chk("t1_ctrl_deq", ctrl_fifo_deq, 1); chk("t1_int_deq", int_fifo_deq, 1); chk("t1_nin_deq", nin_fifo_deq, 1);
        post();
        // SUB acc-int -> BUS, wraps
        ctrl_q.push_back(8'b01_10_00_0_1); int_q.push_back(8'd20); drive();
        at_neg();
        chk("t1_nout_enq", nout_fifo_enq, 1); chk("t1_nout_data", nout_fifo_data_in, 12);
        chk("t1_bus_enq", bus_fifo_enq, 0); chk("t1_acc", acc_out, 12);
        chk("t2_int_deq", int_fifo_deq, 1); chk("t2_nin_deq", nin_fifo_deq, 0);
        post();
        // XOR int^int -> both, single int pop
        ctrl_q.push_back(8'b11_00_00_1_1); int_q.push_back(8'h3C); drive();
        at_neg();
        chk("t2_bus_enq", bus_fifo_enq, 1); chk("t2_bus_data", bus_fifo_data_in, 248);
        chk("t2_nout_enq", nout_fifo_enq, 0); chk("t3_int_deq", int_fifo_deq, 1);
        post();
        at_neg();
        chk("t3_nout_enq", nout_fifo_enq, 1); chk("t3_bus_enq", bus_fifo_enq, 1);
        chk("t3_data", nout_fifo_data_in, 0); chk("t3_acc", acc_out, 0);
        post();

        // NOUT backpressure holds WB and blocks the next issue
        nout_fifo_full = 1'b1; ctrl_q.push_back(8'b00_11_11_1_0); drive();
        at_neg(); chk("t4_issue", ctrl_fifo_deq, 1);
        post();
        ctrl_q.push_back(8'b00_00_11_0_0); int_q.push_back(8'd9); drive();
        repeat (5) begin
            at_neg();
            chk("t4_stall_enq", nout_fifo_enq, 0); chk("t4_stall_ctrl", ctrl_fifo_deq, 0);
            chk("t4_stall_int", int_fifo_deq, 0);
            post();
        end
        nout_fifo_full = 1'b0; drive();
        at_neg(); chk("t4_rel_enq", nout_fifo_enq, 1); chk("t4_rel_issue", ctrl_fifo_deq, 1);
        post();

        // Missing NIN operand stalls issue
        ctrl_q.push_back(8'b00_01_11_0_0); drive();
        repeat (3) begin
            at_neg();
            chk("t5_ctrl_deq", ctrl_fifo_deq, 0); chk("t5_nin_deq", nin_fifo_deq, 0);
            chk("t5_cnt", inst_count, 5);
            post();
        end
        nin_q.push_back(8'd3); drive();
        at_neg(); chk("t5_go_ctrl", ctrl_fifo_deq, 1); chk("t5_go_nin", nin_fifo_deq, 1);
        post();
        at_neg(); chk("t5_cnt2", inst_count, 6); chk("t5_acc", acc_out, 3);
        post();

        // Reset with a pending WB entry discards it
        nout_fifo_full = 1'b1; ctrl_q.push_back(8'b00_11_11_1_1); drive();
        at_neg(); post();
        at_neg(); chk("t6_blocked", nout_fifo_enq, 0);
        post();
        reset = 1'b1; model_reset(); drive();
        at_neg();
        chk("t6_nout_enq", nout_fifo_enq, 0); chk("t6_bus_enq", bus_fifo_enq, 0);
        chk("t6_acc", acc_out, 0); chk("t6_cnt", inst_count, 0); chk("t6_idle", idle, 1);
        post();
        reset = 1'b0; nout_fifo_full = 1'b0; drive();

        for (int i = 0; i < 3000; i++) begin
            at_neg();
            post();
            if (ctrl_q.size() < 4 && $urandom_range(0, 2) != 0) ctrl_q.push_back(8'($urandom));
            if (int_q.size() < 4 && $urandom_range(0, 1) != 0) int_q.push_back(8'($urandom));
            if (nin_q.size() < 4 && $urandom_range(0, 1) != 0) nin_q.push_back(8'($urandom));
            nout_fifo_full = ($urandom_range(0, 3) == 0);
            bus_fifo_full  = ($urandom_range(0, 3) == 0);
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 299) == 0) begin
                reset = 1'b1;
                model_reset();
            end
            drive();
        end
        at_neg();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
